// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central sequencing block for the 5-stage pipeline. Produces the per-stage
// write-enable / flush controls for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
// It resolves load-use hazards that forwarding cannot cover, squashes the
// fetched slot on taken branches/jumps, freezes the pipe while the data
// memory is busy (with a timeout into ERROR), handles a sticky halt request,
// and keeps saturating stall/flush performance counters.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   IFID_rs/rt/UsesRt       source operands of the instruction in ID
//   IDEXE_rd/MemRead        destination / load flag of the instruction in EXE
//   BranchTaken/JumpSignal  control-flow redirect resolved in ID
//   EXEMEM_MemRead/Write    data-memory access in MEM
//   MemReady                data memory completes the access this cycle
//   HaltReq                 single-cycle halt request pulse
//   PCWrite .. MEMWB_Flush  pipeline register controls (combinational)
//   Halted, MemError        terminal-state indicators (registered)
//   StallCycles, FlushCount saturating performance counters (registered)
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_UsesRt,
    input  logic [4:0]       IDEXE_rd,
    input  logic             IDEXE_MemRead,
    input  logic             BranchTaken,
    input  logic             JumpSignal,
    input  logic             EXEMEM_MemRead,
    input  logic             EXEMEM_MemWrite,
    input  logic             MemReady,
    input  logic             HaltReq,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEXE_Write,
    output logic             IDEXE_Flush,
    output logic             EXEMEM_Write,
    output logic             MEMWB_Flush,
    output logic             Halted,
    output logic             MemError,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    // Wait counter wide enough for the largest legal timeout (65535).
    localparam int unsigned       WAIT_W    = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                  input logic             en);
        logic [CNT_W-1:0] res;
        if (en && (val != {CNT_W{1'b1}})) begin
            res = val + CNT_W'(1'b1);
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_t            state_q,      state_d;
    logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic              halt_pend_q,  halt_pend_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

    logic mem_busy_s;
    logic load_use_s;
    logic redirect_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic ifid_flush_s;
    logic idexe_write_s;
    logic idexe_flush_s;
    logic exemem_write_s;
    logic memwb_flush_s;

    // Hazard terms; register 0 is never a real producer, so it cannot stall.
    assign mem_busy_s = (EXEMEM_MemRead | EXEMEM_MemWrite) & ~MemReady;
    assign load_use_s = IDEXE_MemRead & (IDEXE_rd != 5'd0) &
                        ((IFID_rs == IDEXE_rd) |
                         (IFID_UsesRt & (IFID_rt == IDEXE_rd)));
    assign redirect_s = BranchTaken | JumpSignal;

    // Next-state, stage controls, wait/halt bookkeeping and counter updates.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        halt_pend_d    = halt_pend_q;
        pc_write_s     = 1'b0;
        ifid_write_s   = 1'b0;
        ifid_flush_s   = 1'b0;
        idexe_write_s  = 1'b0;
        idexe_flush_s  = 1'b0;
        exemem_write_s = 1'b0;
        memwb_flush_s  = 1'b0;

        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                halt_pend_d = halt_pend_q | HaltReq;
                if (mem_busy_s) begin
                    // Freeze everything upstream of MEM; bubble into WB.
                    memwb_flush_s = 1'b1;
                    wait_cnt_d    = wait_cnt_q + WAIT_W'(1'b1);
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end else begin
                    wait_cnt_d = {WAIT_W{1'b0}};
                    if (load_use_s) begin
                        // Hold PC and IF/ID, inject a bubble into EXE. Any
                        // redirect is re-evaluated once the load has moved on.
                        idexe_write_s  = 1'b1;
                        idexe_flush_s  = 1'b1;
                        exemem_write_s = 1'b1;
                    end else if (redirect_s) begin
                        pc_write_s     = 1'b1;
                        ifid_write_s   = 1'b1;
                        ifid_flush_s   = 1'b1;
                        idexe_write_s  = 1'b1;
                        exemem_write_s = 1'b1;
                    end else begin
                        pc_write_s     = 1'b1;
                        ifid_write_s   = 1'b1;
                        idexe_write_s  = 1'b1;
                        exemem_write_s = 1'b1;
                    end
                    // The current cycle still executes; the halt lands next.
                    if (halt_pend_q) begin
                        state_d     = ST_HALTED;
                        halt_pend_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALTED, ST_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase

        if ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) begin
            stall_cnt_d = sat_inc(stall_cnt_q, ~pc_write_s);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        flush_cnt_d = sat_inc(flush_cnt_q, ifid_flush_s);
    end

    // State, wait counter, pending halt and performance counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= {WAIT_W{1'b0}};
            halt_pend_q <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            halt_pend_q <= halt_pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are zero-latency; gating with reset_n keeps every enable and
    // flush low for the whole time reset is held, not just after a clock.
    assign PCWrite      = pc_write_s     & reset_n;
    assign IFID_Write   = ifid_write_s   & reset_n;
    assign IFID_Flush   = ifid_flush_s   & reset_n;
    assign IDEXE_Write  = idexe_write_s  & reset_n;
    assign IDEXE_Flush  = idexe_flush_s  & reset_n;
    assign EXEMEM_Write = exemem_write_s & reset_n;
    assign MEMWB_Flush  = memwb_flush_s  & reset_n;

    assign Halted      = (state_q == ST_HALTED);
    assign MemError    = (state_q == ST_ERROR);
    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;

endmodule
